// File: rtl/hazard_ctrl_unit.sv
// Hazard detection, multi-cycle stall FSM, EX-stage forwarding and branch flush
// control for the 5-stage pipeline, with saturating stall/flush counters.

module hazard_fwd_sel #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             mem_regWrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_regWrite,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       sel
);
    // MEM/WB producers are younger-first: MEM wins over WB.
    always_comb begin
        sel = 2'b00;
        if (mem_regWrite && mem_rd != '0 && mem_rd == src)
            sel = 2'b10;
        else if (wb_regWrite && wb_rd != '0 && wb_rd == src)
            sel = 2'b01;
    end
endmodule

module hazard_ctrl_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memRead,
    input  logic             ex_regWrite,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_regWrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_regWrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             pcSrc,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             hazardMux,
    output logic             flushIFID,
    output logic             flushIDEX,
    output logic             flushEXMEM,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);
    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_nxt;
    logic [2:0] rem, rem_nxt;
    logic [2:0] need;
    logic       ex_hit, mem_hit;
    logic       stall, flush;

    logic [1:0][REG_W-1:0] ex_src;
    logic [1:0][1:0]       fwd_sel;

    function automatic logic prod_match(input logic we, input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                        input logic uses_rt);
        return we && rd != '0 && (rd == rs || (uses_rt && rd == rt));
    endfunction

    assign ex_hit  = prod_match(ex_regWrite,  ex_rd,  id_rs, id_rt, id_uses_rt);
    assign mem_hit = prod_match(mem_regWrite, mem_rd, id_rs, id_rt, id_uses_rt);

    // WB never stalls: the register bank writes before it reads.
    always_comb begin
        need = 3'd0;
        if (FWD_EN != 0) begin
            if (ex_hit && ex_memRead) need = 3'(LOAD_LAT);
        end else begin
            if (ex_hit)       need = 3'd2;
            else if (mem_hit) need = 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        stall     = 1'b0;
        flush     = 1'b0;
        if (pcSrc) begin
            flush     = 1'b1;
            state_nxt = RUN;
            rem_nxt   = 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (id_valid && need != 3'd0) begin
                        stall = 1'b1;
                        if (need > 3'd1) begin
                            state_nxt = STALL;
                            rem_nxt   = need - 3'd1;
                        end
                    end
                end
                STALL: begin
                    stall   = 1'b1;
                    rem_nxt = rem - 3'd1;
                    if (rem == 3'd1) begin
                        state_nxt = RUN;
                        rem_nxt   = 3'd0;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    rem_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            rem        <= 3'd0;
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (stall && stallCount != '1) stallCount <= stallCount + 1'b1;
            if (pcSrc && flushCount != '1) flushCount <= flushCount + 1'b1;
        end
    end

    assign ex_src = {ex_rt, ex_rs};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hazard_fwd_sel #(.REG_W(REG_W)) u_sel (
            .src          (ex_src[g]),
            .mem_regWrite (mem_regWrite),
            .mem_rd       (mem_rd),
            .wb_regWrite  (wb_regWrite),
            .wb_rd        (wb_rd),
            .sel          (fwd_sel[g])
        );
    end

    // Holding reset freezes the pipeline with a bubble in ID/EX.
    assign PCWrite    = reset_n & ~stall;
    assign IFIDWrite  = reset_n & ~stall;
    assign hazardMux  = ~reset_n | stall;
    assign flushIFID  = reset_n & flush;
    assign flushIDEX  = reset_n & flush;
    assign flushEXMEM = reset_n & flush;
    assign fwdA       = (FWD_EN != 0 && reset_n) ? fwd_sel[0] : 2'b00;
    assign fwdB       = (FWD_EN != 0 && reset_n) ? fwd_sel[1] : 2'b00;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Three parameter variants of hazard_ctrl_unit share one stimulus stream and are
// checked every cycle against a cycle-count reference model.

module tb_hazard_ctrl_unit;
    localparam int LATS [3] = '{3, 4, 1};
    localparam int FWES [3] = '{1, 0, 1};
    localparam int MAXC [3] = '{65535, 65535, 15};

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic       id_valid, id_uses_rt, ex_memRead, ex_regWrite, mem_regWrite, wb_regWrite, pcSrc;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

    logic [9:0]  obs_ctl [3];
    logic [15:0] obs_sc  [3];
    logic [15:0] obs_fc  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 2) ? 4 : 16;
        logic          pcw, ifw, hzm, f1, f2, f3;
        logic [1:0]    fa, fb;
        logic [CW-1:0] sc, fc;
        hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(LATS[g]), .FWD_EN(FWES[g]), .CNT_W(CW)) dut (
            .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
            .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memRead(ex_memRead),
            .ex_regWrite(ex_regWrite), .ex_rd(ex_rd), .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
            .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .pcSrc(pcSrc), .PCWrite(pcw), .IFIDWrite(ifw),
            .hazardMux(hzm), .flushIFID(f1), .flushIDEX(f2), .flushEXMEM(f3), .fwdA(fa), .fwdB(fb),
            .stallCount(sc), .flushCount(fc)
        );
        assign obs_ctl[g] = {pcw, ifw, hzm, f1, f2, f3, fa, fb};
        assign obs_sc[g]  = 16'(sc);
        assign obs_fc[g]  = 16'(fc);
    end

    int vectors = 0;
    int miscompares = 0;

    // Model: stall cycles still owed after the current one, plus event tallies.
    int          left [3], stalls [3], flushes [3], nreq [3];
    logic [9:0]  exp_ctl [3];
    logic [15:0] exp_sc [3], exp_fc [3];

    function automatic bit hit(logic we, logic [4:0] rd);
        return we && rd != 0 && (rd == id_rs || (id_uses_rt && rd == id_rt));
    endfunction

    function automatic logic [1:0] fwd_of(logic [4:0] src);
        if (mem_regWrite && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_regWrite && wb_rd != 0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            left[k] = 0; stalls[k] = 0; flushes[k] = 0;
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 3; k++) begin
            int n;
            bit stl;
            logic [1:0] a, b;
            if (FWES[k] != 0) n = (hit(ex_regWrite, ex_rd) && ex_memRead) ? LATS[k] : 0;
            else n = hit(ex_regWrite, ex_rd) ? 2 : (hit(mem_regWrite, mem_rd) ? 1 : 0);
            nreq[k] = n;
            stl = !pcSrc && (left[k] > 0 || (id_valid && n > 0));
            a = (FWES[k] != 0) ? fwd_of(ex_rs) : 2'b00;
            b = (FWES[k] != 0) ? fwd_of(ex_rt) : 2'b00;
            if (!reset_n) exp_ctl[k] = 10'b0010000000;
            else exp_ctl[k] = {!stl, !stl, stl, pcSrc, pcSrc, pcSrc, a, b};
            exp_sc[k] = 16'(stalls[k]);
            exp_fc[k] = 16'(flushes[k]);
        end
    endtask

    task automatic model_advance();
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (pcSrc) begin
                left[k] = 0;
                if (flushes[k] < MAXC[k]) flushes[k]++;
            end else if (left[k] > 0 || (id_valid && nreq[k] > 0)) begin
                left[k] = (left[k] > 0) ? left[k] - 1 : nreq[k] - 1;
                if (stalls[k] < MAXC[k]) stalls[k]++;
            end
        end
    endtask

    task automatic settle();
        #1 model_eval();
    endtask

    task automatic advance();
        model_advance();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        id_valid = 1'b1; id_uses_rt = 1'b0; ex_memRead = 1'b0; ex_regWrite = 1'b0;
        mem_regWrite = 1'b0; wb_regWrite = 1'b0; pcSrc = 1'b0;
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        model_reset();
        clear_inputs();
    endtask

    task automatic set_load_use();
        ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_rd = 5; id_rs = 5; id_valid = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clock);
        for (int c = 0; c < 2; c++) begin
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== 10'b0010000000 || obs_sc[k] !== 0 || obs_fc[k] !== 0) begin
                    miscompares++;
                    $display("FAIL reset dut%0d ctl=%b sc=%0d fc=%0d want ctl=0010000000 sc=0 fc=0",
                             k, obs_ctl[k], obs_sc[k], obs_fc[k]);
                end
            end
            advance();
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            id_rs = 5'($urandom_range(1, 31)); id_rt = id_rs; id_uses_rt = 1'b1;
            ex_rs = 5'($urandom_range(0, 31)); ex_rt = 5'($urandom_range(0, 31));
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== exp_ctl[k] || obs_ctl[k] !== 10'b1100000000) begin
                    miscompares++;
                    $display("FAIL no_hazard dut%0d cyc%0d ctl got %b want %b", k, c, obs_ctl[k], exp_ctl[k]);
                end
            end
            advance();
        end
        settle();
        vectors++;
        if (obs_sc[0] !== 16'd0) begin
            miscompares++;
            $display("FAIL no_hazard_count stallCount got %0d want 0", obs_sc[0]);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) set_load_use(); else clear_inputs();
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== exp_ctl[k] || obs_sc[k] !== exp_sc[k] || obs_fc[k] !== exp_fc[k]) begin
                    miscompares++;
                    $display("FAIL load_use dut%0d cyc%0d ctl/sc/fc got %b/%0d/%0d want %b/%0d/%0d",
                             k, c, obs_ctl[k], obs_sc[k], obs_fc[k], exp_ctl[k], exp_sc[k], exp_fc[k]);
                end
            end
            if (c == 3) begin
                vectors++;
                if (obs_sc[0] !== 16'd3 || obs_ctl[0][9:7] !== 3'b110) begin
                    miscompares++;
                    $display("FAIL load_use_len stallCount=%0d ctl=%b want 3 / 110", obs_sc[0], obs_ctl[0][9:7]);
                end
            end
            advance();
        end
    endtask

    task automatic test_forwarding();
        logic [1:0] want [3] = '{2'b10, 2'b01, 2'b00};
        do_reset();
        id_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_regWrite = (c != 1); wb_regWrite = 1'b1;
            mem_rd = 7; wb_rd = 7; ex_rs = (c == 2) ? 5'd0 : 5'd7; ex_rt = 5'd7;
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== exp_ctl[k]) begin
                    miscompares++;
                    $display("FAIL forwarding dut%0d cyc%0d ctl got %b want %b", k, c, obs_ctl[k], exp_ctl[k]);
                end
            end
            vectors++;
            if (obs_ctl[0][3:2] !== want[c] || obs_ctl[1][3:0] !== 4'b0000) begin
                miscompares++;
                $display("FAIL fwdA cyc%0d got %b (nofwd %b) want %b (nofwd 0000)",
                         c, obs_ctl[0][3:2], obs_ctl[1][3:0], want[c]);
            end
            advance();
        end
    endtask

    task automatic test_nofwd_stalls();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            id_rt = 3; id_uses_rt = 1'b1;
            if (c == 0) begin ex_regWrite = 1'b1; ex_rd = 3; end
            if (c == 3) begin mem_regWrite = 1'b1; mem_rd = 3; end
            if (c == 5 || c == 6) begin wb_regWrite = 1'b1; wb_rd = 3; end
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== exp_ctl[k] || obs_sc[k] !== exp_sc[k]) begin
                    miscompares++;
                    $display("FAIL nofwd dut%0d cyc%0d ctl/sc got %b/%0d want %b/%0d",
                             k, c, obs_ctl[k], obs_sc[k], exp_ctl[k], exp_sc[k]);
                end
            end
            advance();
        end
        settle();
        vectors++;
        if (obs_sc[1] !== 16'd3) begin
            miscompares++;
            $display("FAIL nofwd_count stallCount got %0d want 3", obs_sc[1]);
        end
    endtask

    task automatic test_branch_abort();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c < 2) set_load_use(); else clear_inputs();
            pcSrc = (c == 1);
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== exp_ctl[k] || obs_sc[k] !== exp_sc[k] || obs_fc[k] !== exp_fc[k]) begin
                    miscompares++;
                    $display("FAIL branch dut%0d cyc%0d ctl/sc/fc got %b/%0d/%0d want %b/%0d/%0d",
                             k, c, obs_ctl[k], obs_sc[k], obs_fc[k], exp_ctl[k], exp_sc[k], exp_fc[k]);
                end
            end
            vectors++;
            if ((c == 1 && obs_ctl[0][9:4] !== 6'b110111) ||
                (c == 2 && (obs_ctl[0][9:4] !== 6'b110000 || obs_sc[0] !== 1 || obs_fc[0] !== 1))) begin
                miscompares++;
                $display("FAIL branch_fixed cyc%0d ctl=%b sc=%0d fc=%0d", c, obs_ctl[0][9:4], obs_sc[0], obs_fc[0]);
            end
            advance();
        end
    endtask

    task automatic test_saturation_and_async_reset();
        do_reset();
        set_load_use();
        for (int c = 0; c < 20; c++) begin
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== exp_ctl[k] || obs_sc[k] !== exp_sc[k]) begin
                    miscompares++;
                    $display("FAIL saturate dut%0d cyc%0d ctl/sc got %b/%0d want %b/%0d",
                             k, c, obs_ctl[k], obs_sc[k], exp_ctl[k], exp_sc[k]);
                end
            end
            advance();
        end
        settle();
        vectors++;
        if (obs_sc[2] !== 16'd15 || obs_sc[0] !== 16'd20) begin
            miscompares++;
            $display("FAIL saturate_final cnt4=%0d cnt16=%0d want 15/20", obs_sc[2], obs_sc[0]);
        end
        // Mid-cycle, mid-stall reset: must act before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_ctl[k] !== 10'b0010000000 || obs_sc[k] !== 0 || obs_fc[k] !== 0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d ctl=%b sc=%0d fc=%0d want 0010000000/0/0",
                         k, obs_ctl[k], obs_sc[k], obs_fc[k]);
            end
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        clear_inputs();
        settle();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_ctl[k] !== 10'b1100000000 || obs_ctl[k] !== exp_ctl[k]) begin
                miscompares++;
                $display("FAIL post_reset dut%0d ctl got %b want 1100000000", k, obs_ctl[k]);
            end
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            id_valid = ($urandom_range(0, 7) != 0); id_uses_rt = 1'($urandom);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            ex_regWrite = 1'($urandom); ex_memRead = 1'($urandom);
            mem_regWrite = 1'($urandom); wb_regWrite = 1'($urandom);
            pcSrc = ($urandom_range(0, 9) == 0);
            settle();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_ctl[k] !== exp_ctl[k] || obs_sc[k] !== exp_sc[k] || obs_fc[k] !== exp_fc[k]) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc%0d ctl/sc/fc got %b/%0d/%0d want %b/%0d/%0d",
                             k, c, obs_ctl[k], obs_sc[k], obs_fc[k], exp_ctl[k], exp_sc[k], exp_fc[k]);
                end
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_no_hazard();
        test_load_use();
        test_forwarding();
        test_nofwd_stalls();
        test_branch_abort();
        test_saturation_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline. It replaces the fixed single-bubble hazard logic that drives hazardMux and IFIDWrite.
- Detects RAW hazards between ID and the EX/MEM/WB producers and generates multi-cycle stalls through a counter FSM.
- Produces EX-stage forwarding selects and IF/ID, ID/EX and EX/MEM flushes on a taken branch.
- Keeps saturating stall and flush performance counters.
- Sits beside the control unit and drives PCWrite, IFIDWrite, hazardMux and the flush inputs of the pipeline registers.

Parameters:
- REG_W, 5: register-address width.
- LOAD_LAT, 1: stall cycles for a load-use hazard, range 1..4.
- FWD_EN, 1: 1 = forwarding enabled; 0 = no forwarding, ALU RAW hazards are resolved by stalling.
- CNT_W, 16: width of the performance counters.

Ports:
- clock, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous active-low reset.
- id_valid, in, 1: the IF/ID instruction is valid.
- id_rs, in, REG_W: ID source register 1.
- id_rt, in, REG_W: ID source register 2.
- id_uses_rt, in, 1: the ID instruction reads rt.
- ex_rs, in, REG_W: ID/EX rs, used for forwarding.
- ex_rt, in, REG_W: ID/EX rt, used for forwarding.
- ex_memRead, in, 1: the EX instruction is a load.
- ex_regWrite, in, 1: the EX instruction writes a register.
- ex_rd, in, REG_W: EX destination register.
- mem_regWrite, in, 1: the MEM instruction writes a register.
- mem_rd, in, REG_W: MEM destination register.
- wb_regWrite, in, 1: the WB instruction writes a register.
- wb_rd, in, REG_W: WB destination register.
- pcSrc, in, 1: branch taken, resolved in MEM.
- PCWrite, out, 1: PC update enable.
- IFIDWrite, out, 1: IF/ID write enable.
- hazardMux, out, 1: 1 = zero the control word into ID/EX (bubble).
- flushIFID, out, 1: clear IF/ID.
- flushIDEX, out, 1: clear ID/EX.
- flushEXMEM, out, 1: clear EX/MEM.
- fwdA, out, 2: ALU operand A select. 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- fwdB, out, 2: ALU operand B select, same encoding as fwdA.
- stallCount, out, CNT_W: stall cycles since reset, saturating.
- flushCount, out, CNT_W: taken-branch flushes since reset, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to RUN, the internal counter rem to 0, and both perf counters to 0.
  - While reset is held, the outputs are PCWrite=0, IFIDWrite=0, hazardMux=1, all flushes 0, fwdA=fwdB=00.
- Register 0 never matches. A match is "producer regWrite=1, rd!=0, rd==id_rs, or rd==id_rt when id_uses_rt=1".
- Hazard detection runs only in RUN with id_valid=1:
  - FWD_EN=1: an EX load match (ex_memRead=1) requests N=LOAD_LAT stall cycles.
  - FWD_EN=0: an EX match requests N=2. Otherwise a MEM match requests N=1. A WB producer requests no stall, because the register bank writes before it reads in the same cycle.
  - If both EX and MEM match, the larger N is used.
- Stall outputs: PCWrite=0, IFIDWrite=0, hazardMux=1, asserted combinationally in the detection cycle.
  - If N>1: rem<=N-1 and the FSM enters STALL.
  - If N=1: the FSM stays in RUN.
- STALL state:
  - Stall outputs are held.
  - No new detection is made.
  - rem decrements each cycle.
  - When rem==1 on the clock edge, the FSM goes to RUN and hazards are re-evaluated in the next cycle.
- Total stall length equals N exactly.
- Taken branch (pcSrc=1) has the highest priority, in any state:
  - Combinationally: flushIFID=flushIDEX=flushEXMEM=1, PCWrite=1, IFIDWrite=1, hazardMux=0.
  - Next state is RUN with rem=0, which aborts any stall.
  - flushCount increments once per cycle in which pcSrc=1.
- Forwarding (combinational, FWD_EN=1):
  - fwdA=10 if mem_regWrite=1, mem_rd!=0 and mem_rd==ex_rs.
  - Else fwdA=01 if wb_regWrite=1, wb_rd!=0 and wb_rd==ex_rs.
  - Else fwdA=00.
  - MEM has priority over WB. fwdB is identical using ex_rt.
  - FWD_EN=0 forces fwdA=fwdB=00.
- stallCount increments on every clock edge in which stall outputs are asserted and pcSrc=0.
- Both perf counters saturate at all-ones; they do not wrap.
- Default outputs in RUN with no hazard: PCWrite=1, IFIDWrite=1, hazardMux=0, flushes 0.
- Reset mid-stall takes effect immediately, asynchronously. No residual stall remains after release.

Test Plan:
- Reset, then release with no hazards (FWD_EN=1): PCWrite=1, IFIDWrite=1, hazardMux=0, fwd=00; after 10 cycles stallCount=0.
- Load-use, LOAD_LAT=3: ex_memRead=1, ex_rd=5, id_rs=5 → stall outputs for exactly 3 cycles, then RUN; stallCount=3.
- Forwarding: mem_rd=ex_rs=7, wb_rd=ex_rs=7, both regWrite=1 → fwdA=10. With mem_regWrite=0 → fwdA=01. With ex_rs=0 → fwdA=00.
- FWD_EN=0: EX match gives a 2-cycle stall; MEM-only match gives 1 cycle; WB-only match gives no stall.
- pcSrc=1 in the second cycle of a 3-cycle load stall → all flushes=1 and PCWrite=1 that cycle; the following cycle is RUN with no stall; flushCount=1, stallCount=1.
- CNT_W=4, continuous hazard for 20 stall cycles → stallCount holds at 15. Asserting reset_n=0 mid-stall clears all counters asynchronously.
